// File: rtl/debug_bus_master.sv
// debug_bus_master: register-bus initiator for the CPU debug port with setup/strobe/hold timing.
// Optional DBG_REQ wait state with 255-cycle timeout: define DEBUG_MASTER_REQ_WAIT_EN.
module debug_bus_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_WRITE,
    input  logic [2:0] CMD_ADDR,
    input  logic [7:0] CMD_DATA,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [7:0] RSP_DATA,
    output logic [2:0] DBG_ADDR,
    output logic [7:0] DBG_DOUT,
    input  logic [7:0] DBG_DIN,
    output logic       DBG_RDN,
    output logic       DBG_WRN,
    output logic       DBG_OE,
`ifdef DEBUG_MASTER_REQ_WAIT_EN
    input  logic       DBG_REQ,
    output logic       REQ_TIMEOUT,
`endif
    output logic       BUSY
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;
`ifdef DEBUG_MASTER_REQ_WAIT_EN
    localparam logic [2:0] ST_WAITREQ = 3'd5;
`endif

    // A zero phase length would stall the down-counter, so it runs as one cycle.
    localparam logic [7:0] C_SETUP  = (SETUP_CYCLES == 0)  ? 8'd1 : 8'(SETUP_CYCLES);
    localparam logic [7:0] C_STROBE = (STROBE_CYCLES == 0) ? 8'd1 : 8'(STROBE_CYCLES);
    localparam logic [7:0] C_HOLD   = (HOLD_CYCLES == 0)   ? 8'd1 : 8'(HOLD_CYCLES);

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic       r_write;
    logic [2:0] r_addr;
    logic [7:0] r_dout;
    logic       r_oe;
    logic       r_rdn;
    logic       r_wrn;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       r_busy;
    logic       w_last;
`ifdef DEBUG_MASTER_REQ_WAIT_EN
    logic       r_timeout;
    assign REQ_TIMEOUT = r_timeout;
`endif

    assign w_last    = (r_cnt <= 8'd1);
    assign CMD_READY = (r_state == ST_IDLE) && !RESET;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_DATA  = r_rsp_data;
    assign DBG_ADDR  = r_addr;
    assign DBG_DOUT  = r_dout;
    assign DBG_RDN   = r_rdn;
    assign DBG_WRN   = r_wrn;
    assign DBG_OE    = r_oe;
    assign BUSY      = r_busy;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_write     <= 1'b0;
            r_addr      <= 3'd0;
            r_dout      <= 8'd0;
            r_oe        <= 1'b0;
            r_rdn       <= 1'b1;
            r_wrn       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'd0;
            r_busy      <= 1'b0;
`ifdef DEBUG_MASTER_REQ_WAIT_EN
            r_timeout   <= 1'b0;
`endif
        end else begin
`ifdef DEBUG_MASTER_REQ_WAIT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        r_write <= CMD_WRITE;
                        r_addr  <= CMD_ADDR;
                        if (CMD_WRITE) r_dout <= CMD_DATA;
                        r_oe    <= CMD_WRITE;
                        r_cnt   <= C_SETUP;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_last) begin
                        r_cnt   <= C_STROBE;
                        r_state <= ST_STROBE;
                        if (r_write) r_wrn <= 1'b0;
                        else         r_rdn <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (w_last) begin
                        r_wrn   <= 1'b1;
                        r_rdn   <= 1'b1;
                        if (!r_write) r_rsp_data <= DBG_DIN;
                        r_cnt   <= C_HOLD;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_write) begin
                        r_oe <= 1'b0;
`ifdef DEBUG_MASTER_REQ_WAIT_EN
                        r_cnt   <= 8'd255;
                        r_state <= ST_WAITREQ;
`else
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
`ifdef DEBUG_MASTER_REQ_WAIT_EN
                ST_WAITREQ: begin
                    if (!DBG_REQ) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_bus_master.sv
// tb_debug_bus_master: directed vectors and corner-case sequences for debug_bus_master.
// Covers default timing, RESET abort, back-to-back writes and a 0/1/255 timing instance.
module tb_debug_bus_master;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CMD_VALID, CMD_READY, CMD_WRITE;
    logic [2:0] CMD_ADDR;
    logic [7:0] CMD_DATA;
    logic       RSP_VALID, RSP_READY;
    logic [7:0] RSP_DATA;
    logic [2:0] DBG_ADDR;
    logic [7:0] DBG_DOUT, DBG_DIN;
    logic       DBG_RDN, DBG_WRN, DBG_OE, BUSY;

    logic       c2_valid, c2_ready, c2_write;
    logic [2:0] c2_addr_i, c2_addr;
    logic [7:0] c2_data, c2_rsp_data, c2_dout;
    logic       c2_rsp_valid, c2_rdn, c2_wrn, c2_oe, c2_busy;

`ifdef DEBUG_MASTER_REQ_WAIT_EN
    logic DBG_REQ, REQ_TIMEOUT, c2_to;
    localparam int WQ = 1;
`else
    localparam int WQ = 0;
`endif
    localparam int EXP_RDY = 8 + WQ;

    always #5 CLK = ~CLK;

    debug_bus_master u_dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .DBG_ADDR(DBG_ADDR), .DBG_DOUT(DBG_DOUT), .DBG_DIN(DBG_DIN),
        .DBG_RDN(DBG_RDN), .DBG_WRN(DBG_WRN), .DBG_OE(DBG_OE),
`ifdef DEBUG_MASTER_REQ_WAIT_EN
        .DBG_REQ(DBG_REQ), .REQ_TIMEOUT(REQ_TIMEOUT),
`endif
        .BUSY(BUSY)
    );

    debug_bus_master #(
        .SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(255)
    ) u_dut2 (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(c2_valid), .CMD_READY(c2_ready),
        .CMD_WRITE(c2_write), .CMD_ADDR(c2_addr_i), .CMD_DATA(c2_data),
        .RSP_VALID(c2_rsp_valid), .RSP_READY(1'b0), .RSP_DATA(c2_rsp_data),
        .DBG_ADDR(c2_addr), .DBG_DOUT(c2_dout), .DBG_DIN(8'h00),
        .DBG_RDN(c2_rdn), .DBG_WRN(c2_wrn), .DBG_OE(c2_oe),
`ifdef DEBUG_MASTER_REQ_WAIT_EN
        .DBG_REQ(1'b0), .REQ_TIMEOUT(c2_to),
`endif
        .BUSY(c2_busy)
    );

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] din;
        logic [7:0] exp;
    } cmd_t;

    cmd_t vec[5];
    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns just after the accepting edge (sample index 0).
    task automatic wait_accept(input string nm);
        int n = 0;
        while (!CMD_READY && n < 600) begin
            tick();
            n++;
        end
        check({nm, "_accept"}, int'(CMD_READY), 1);
        tick();
    endtask

    task automatic run_cmd(input string nm, input cmd_t c);
        int lo_n = 0, lo_first = -1, oe_n = 0, oth = 0, abad = 0;
        int rdy = -1, rv_first = -1, rv_n = 0;
        logic sel_lo, oth_lo;
        CMD_WRITE = c.wr;
        CMD_ADDR  = c.addr;
        CMD_DATA  = c.data;
        DBG_DIN   = c.din;
        CMD_VALID = 1'b1;
        wait_accept(nm);
        CMD_VALID = 1'b0;
        for (int k = 0; k <= EXP_RDY; k++) begin
            if (k > 0) tick();
            sel_lo = c.wr ? !DBG_WRN : !DBG_RDN;
            oth_lo = c.wr ? !DBG_RDN : !DBG_WRN;
            if (sel_lo) begin
                lo_n++;
                if (lo_first < 0) lo_first = k;
            end
            if (oth_lo) oth++;
            if (DBG_OE) oe_n++;
            if (DBG_ADDR != c.addr) abad++;
            if (c.wr && DBG_DOUT != c.data) abad++;
            if (CMD_READY && rdy < 0) rdy = k;
            if (RSP_VALID && rv_first < 0) rv_first = k;
            if (k == 6) DBG_DIN = 8'hFF;
        end
        check({nm, "_strobe_first"}, lo_first, 2);
        check({nm, "_strobe_len"}, lo_n, 4);
        check({nm, "_other_strobe"}, oth, 0);
        check({nm, "_oe_len"}, oe_n, c.wr ? 8 : 0);
        check({nm, "_addr_data"}, abad, 0);
        check({nm, "_ready_at"}, rdy, c.wr ? EXP_RDY : -1);
        if (!c.wr) begin
            check({nm, "_rsp_first"}, rv_first, 8);
            check({nm, "_rsp_data"}, int'(RSP_DATA), int'(c.exp));
            for (int k = 0; k < 5; k++) begin
                tick();
                if (RSP_VALID) rv_n++;
            end
            check({nm, "_rsp_hold"}, rv_n, 5);
            RSP_READY = 1'b1;
            tick();
            RSP_READY = 1'b0;
            check({nm, "_rsp_clear"}, int'(RSP_VALID), 0);
            check({nm, "_ready_after_rsp"}, int'(CMD_READY), 1);
            check({nm, "_rsp_data_kept"}, int'(RSP_DATA), int'(c.exp));
        end
    endtask

    task automatic back_to_back();
        logic [7:0] bb[4];
        int idx = 0, np = 0, hi = 0, mingap = 999, obad = 0;
        logic pre, pw;
        bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33; bb[3] = 8'h44;
        pw = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_ADDR  = 3'd1;
        CMD_DATA  = bb[0];
        CMD_VALID = 1'b1;
        for (int k = 0; k < 80; k++) begin
            pre = CMD_READY;
            tick();
            if (pre && CMD_VALID) begin
                idx++;
                if (idx < 4) CMD_DATA = bb[idx];
                else CMD_VALID = 1'b0;
            end
            if (!DBG_WRN) begin
                if (pw) begin
                    if (np < 4 && DBG_DOUT != bb[np]) obad++;
                    if (np > 0 && hi < mingap) mingap = hi;
                    np++;
                end
                hi = 0;
            end else begin
                hi++;
            end
            pw = DBG_WRN;
        end
        CMD_VALID = 1'b0;
        check("bb_accepts", idx, 4);
        check("bb_pulses", np, 4);
        check("bb_order", obad, 0);
        check("bb_gap_ge2", int'(mingap >= 2), 1);
    endtask

    task automatic reset_mid_strobe();
        CMD_WRITE = 1'b1;
        CMD_ADDR  = 3'd4;
        CMD_DATA  = 8'hC3;
        CMD_VALID = 1'b1;
        wait_accept("rst");
        CMD_VALID = 1'b0;
        tick();
        tick();
        tick();
        check("rst_in_strobe", int'(DBG_WRN), 0);
        RESET = 1'b1;
        tick();
        check("rst_wrn", int'(DBG_WRN), 1);
        check("rst_oe", int'(DBG_OE), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_rsp_valid", int'(RSP_VALID), 0);
        RESET = 1'b0;
    endtask

    task automatic slow_instance();
        int n = 0, lo_n = 0, lo_first = -1, rdy = -1, xbad = 0;
        c2_write  = 1'b1;
        c2_addr_i = 3'd6;
        c2_data   = 8'h77;
        c2_valid  = 1'b1;
        while (!c2_ready && n < 50) begin
            tick();
            n++;
        end
        check("p2_accept", int'(c2_ready), 1);
        tick();
        c2_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) tick();
            if (!c2_wrn) begin
                lo_n++;
                if (lo_first < 0) lo_first = k;
            end
            if (!c2_rdn || c2_addr != 3'd6 || c2_dout != 8'h77) xbad++;
            if (c2_ready) begin
                rdy = k;
                break;
            end
        end
        check("p2_strobe_first", lo_first, 1);
        check("p2_strobe_len", lo_n, 1);
        check("p2_ready_at", rdy, 257 + WQ);
        check("p2_bus_hold", xbad, 0);
        check("p2_idle_out", int'({c2_busy, c2_oe, c2_rsp_valid}), 0);
        check("p2_rsp_data", int'(c2_rsp_data), 0);
    endtask

`ifdef DEBUG_MASTER_REQ_WAIT_EN
    task automatic req_wait();
        int busy_n = 0, to_n = 0, rdy = -1;
        DBG_REQ   = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_ADDR  = 3'd2;
        CMD_DATA  = 8'h5E;
        CMD_VALID = 1'b1;
        wait_accept("wq_to");
        CMD_VALID = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) tick();
            if (REQ_TIMEOUT) to_n++;
            if (!BUSY) break;
            busy_n++;
        end
        tick();
        if (REQ_TIMEOUT) to_n++;
        check("wq_busy_len", busy_n, 263);
        check("wq_timeout_pulses", to_n, 1);
        check("wq_idle", int'(CMD_READY), 1);
        CMD_VALID = 1'b1;
        wait_accept("wq_drop");
        CMD_VALID = 1'b0;
        to_n = 0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) tick();
            if (REQ_TIMEOUT) to_n++;
            if (CMD_READY) begin
                rdy = k;
                break;
            end
            if (k == 20) DBG_REQ = 1'b0;
        end
        check("wq_drop_ready_at", rdy, 21);
        check("wq_drop_no_timeout", to_n, 0);
    endtask
`endif

    initial begin
        vec[0] = '{wr: 1'b1, addr: 3'd3, data: 8'hA5, din: 8'h00, exp: 8'h00};
        vec[1] = '{wr: 1'b0, addr: 3'd2, data: 8'h99, din: 8'h3C, exp: 8'h3C};
        vec[2] = '{wr: 1'b1, addr: 3'd7, data: 8'h5A, din: 8'h00, exp: 8'h00};
        vec[3] = '{wr: 1'b0, addr: 3'd0, data: 8'h00, din: 8'h81, exp: 8'h81};
        vec[4] = '{wr: 1'b1, addr: 3'd5, data: 8'h0F, din: 8'h00, exp: 8'h00};

        RESET = 1'b1;
        CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = 3'd0; CMD_DATA = 8'd0;
        RSP_READY = 1'b0; DBG_DIN = 8'd0;
        c2_valid = 1'b0; c2_write = 1'b0; c2_addr_i = 3'd0; c2_data = 8'd0;
`ifdef DEBUG_MASTER_REQ_WAIT_EN
        DBG_REQ = 1'b0;
`endif
        repeat (3) tick();
        check("reset_strobes", int'({DBG_RDN, DBG_WRN}), 3);
        check("reset_addr_dout", int'({DBG_ADDR, DBG_DOUT}), 0);
        check("reset_flags", int'({DBG_OE, RSP_VALID, BUSY}), 0);
        check("reset_rsp_data", int'(RSP_DATA), 0);
        check("reset_ready_low", int'(CMD_READY), 0);
        RESET = 1'b0;
        #1;
        check("ready_after_reset", int'(CMD_READY), 1);

        for (int i = 0; i < 4; i++) run_cmd($sformatf("v%0d", i), vec[i]);
        back_to_back();
        tick();
        reset_mid_strobe();
        run_cmd("post_rst", vec[4]);
        slow_instance();
`ifdef DEBUG_MASTER_REQ_WAIT_EN
        req_wait();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
